// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg: shared slot-state enum, default width and pointer-wrap helper for edge_event_arbiter
package edge_arb_pkg;
  typedef enum logic {EMPTY, HOLD} slot_state_e;
  localparam int DEF_WIDTH = 4;
  function automatic int next_ptr(input int idx, input int width);
    return (idx + 1 >= width) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// rr_pick: combinational round-robin finder of the first set request at or after ptr
module rr_pick #(
  parameter int WIDTH = 4,
  localparam int IDW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             gnt_valid,
  output logic [IDW-1:0]   gnt_id,
  output logic [WIDTH-1:0] gnt_mask
);
  logic [WIDTH-1:0] rot;
  logic [IDW-1:0]   off;
  logic [IDW:0]     sum;
  assign rot = WIDTH'({req, req} >> ptr);
  // lowest set bit of the rotated request is the first candidate at or after ptr
  always_comb begin
    off = '0;
    for (int k = WIDTH - 1; k >= 0; k--)
      if (rot[k]) off = IDW'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    gnt_id = (sum >= (IDW+1)'(WIDTH)) ? IDW'(sum - (IDW+1)'(WIDTH)) : sum[IDW-1:0];
    gnt_mask = WIDTH'(1) << gnt_id;
    gnt_valid = |req;
  end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-bit rising-edge detector with round-robin valid/ready event issue; define EDGE_ARB_SVA_EN to compile embedded assertions
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int IDW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDW-1:0]   evt_id,
  output logic [WIDTH-1:0] pending,
  output logic             overflow
);
  slot_state_e      state, state_next;
  logic [WIDTH-1:0] prev, rise, load_mask, pending_next, gnt_mask;
  logic [IDW-1:0]   ptr, gnt_id;
  logic             gnt_valid, hs, free, load, ovf_next;

  rr_pick #(.WIDTH(WIDTH)) u_pick (
    .req      (pending),
    .ptr      (ptr),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .gnt_mask (gnt_mask)
  );

  assign evt_valid = (state == HOLD);

  // slot is free when empty or being consumed; a rise on a loading bit re-queues it as a new event
  always_comb begin
    rise = sig_in & ~prev;
    hs = evt_valid && evt_ready;
    free = !evt_valid || hs;
    load = free && gnt_valid;
    load_mask = load ? gnt_mask : '0;
    pending_next = (pending & ~load_mask) | rise;
    ovf_next = |(rise & pending & ~load_mask);
    state_next = free ? (gnt_valid ? HOLD : EMPTY) : HOLD;
  end

  // state, edge history, pending queue and slot contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      prev <= '0;
      pending <= '0;
      ptr <= '0;
      evt_id <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      prev <= sig_in;
      pending <= pending_next;
      overflow <= ovf_next;
      if (load) begin
        evt_id <= gnt_id;
        ptr <= IDW'(next_ptr(int'(gnt_id), WIDTH));
      end
    end
  end

`ifdef EDGE_ARB_SVA_EN
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    evt_valid && !evt_ready |=> evt_valid && $stable(evt_id));
  a_id_range: assert property (@(posedge clk) disable iff (rst) int'(evt_id) < WIDTH);
  a_ovf_cause: assert property (@(posedge clk) disable iff (rst) overflow |-> $past(|pending));
  for (genvar g = 0; g < WIDTH; g++) begin : g_rise
    a_rise_queued: assert property (@(posedge clk) disable iff (rst)
      $rose(sig_in[g]) |=> pending[g] || (evt_valid && int'(evt_id) == g));
  end
  // report each accepted event
  always @(posedge clk)
    if (!rst && hs) $info("edge_event_arbiter: issued id %0d", evt_id);
`endif
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed stimulus with a queue-based scoreboard for edge_event_arbiter
module tb_edge_event_arbiter;
  logic       clk, rst, evt_valid, evt_ready, overflow;
  logic [3:0] sig_in, pending;
  logic [1:0] evt_id;
  int         exp_q[$];
  int         checks = 0;
  int         fails = 0;

  edge_event_arbiter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required end before 100000", $time);
    $fatal(1, "watchdog expired");
  end

  // monitor: every handshake pops one expected id
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL evt_unexpected: got id %0d, expected no event", evt_id);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(evt_id) != e) begin
          fails++;
          $display("FAIL evt_id: got %0d, expected %0d", evt_id, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sig_in = '0;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sig_in = '0;
    evt_ready = 1'b1;
    step(2);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;

    // single edge on bit 2
    sig_in = 4'b0100; exp_q.push_back(2);
    step(1);
    chk("single_pending", 32'(pending), 32'h4);
    chk("single_valid_early", 32'(evt_valid), 0);
    step(1);
    chk("single_valid", 32'(evt_valid), 1);
    chk("single_id", 32'(evt_id), 2);
    chk("single_pending_clr", 32'(pending), 0);
    step(1);
    chk("single_drop", 32'(evt_valid), 0);

    // simultaneous edges, then wrap back to id 0
    do_reset();
    evt_ready = 1'b1;
    sig_in = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    step(1);
    chk("sim_pending", 32'(pending), 32'hf);
    step(1);
    chk("sim_first_id", 32'(evt_id), 0);
    chk("sim_pending_after", 32'(pending), 32'he);
    step(4);
    chk("sim_drained", 32'(evt_valid), 0);
    sig_in = 4'b0000;
    step(1);
    sig_in = 4'b0001; exp_q.push_back(0);
    step(2);
    chk("wrap_id", 32'(evt_id), 0);
    chk("wrap_valid", 32'(evt_valid), 1);
    step(1);

    // multibit progression: every upper-bit edge is seen
    do_reset();
    evt_ready = 1'b1;
    sig_in = 4'b1000; exp_q.push_back(3);
    step(1);
    sig_in = 4'b1001; exp_q.push_back(0);
    step(1);
    sig_in = 4'b1011; exp_q.push_back(1);
    step(1);
    sig_in = 4'b1111; exp_q.push_back(2);
    step(4);
    chk("multi_idle", 32'(evt_valid), 0);
    chk("multi_pending", 32'(pending), 0);

    // backpressure holds the slot
    do_reset();
    evt_ready = 1'b0;
    sig_in = 4'b0010; exp_q.push_back(1);
    step(2);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_valid", 32'(evt_valid), 1);
      chk("bp_id", 32'(evt_id), 1);
    end
    evt_ready = 1'b1;
    step(1);
    chk("bp_release", 32'(evt_valid), 0);

    // overflow on a third edge of bit 0
    do_reset();
    evt_ready = 1'b0;
    sig_in = 4'b0001; exp_q.push_back(0);
    step(2);
    chk("ovf_slot_id", 32'(evt_id), 0);
    sig_in = 4'b0000; step(1);
    sig_in = 4'b0001; step(1);
    chk("ovf_requeue_pending", 32'(pending), 1);
    chk("ovf_requeue_none", 32'(overflow), 0);
    sig_in = 4'b0000; step(1);
    sig_in = 4'b0001; step(1);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_pending_kept", 32'(pending), 1);
    step(1);
    chk("ovf_one_cycle", 32'(overflow), 0);
    exp_q.push_back(0);
    evt_ready = 1'b1;
    step(1);
    chk("ovf_reload", 32'(evt_valid), 1);
    step(1);
    chk("ovf_drained", 32'(evt_valid), 0);

    // asynchronous reset mid-stream
    do_reset();
    evt_ready = 1'b0;
    sig_in = 4'b0010;
    step(2);
    sig_in = 4'b0000; step(1);
    sig_in = 4'b0110; step(1);
    chk("mid_pending", 32'(pending), 32'h6);
    chk("mid_valid", 32'(evt_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_pending", 32'(pending), 0);
    chk("mid_rst_id", 32'(evt_id), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    sig_in = '0;
    step(1);
    rst = 1'b0;
    evt_ready = 1'b1;
    step(5);
    chk("post_rst_valid", 32'(evt_valid), 0);
    chk("post_rst_pending", 32'(pending), 0);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
